pcileech_ft601_responder: RTL and testbench

PCILEECH_FT601_RESPONDER -- requirements
Module: pcileech_ft601_responder

---
 rtl/pcileech_ft601_responder.sv | 152 +++++++++++++++
 tb/tb_pcileech_ft601_responder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcileech_ft601_responder.sv
// pcileech_ft601_responder
// FT601-style 32-bit synchronous FIFO bus slave.
// The read FIFO carries host words out to the bus master.
// The write FIFO carries master words in to the host.
// Both FIFOs are first-word-fall-through, so each head word is visible
// combinationally and a burst moves one word per clock in each direction.
module pcileech_ft601_responder #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] ft601_data_in,
    output logic [31:0] ft601_data_out,
    output logic        ft601_data_oe,
    input  logic [3:0]  ft601_be_in,
    output logic [3:0]  ft601_be_out,
    output logic        ft601_rxf_n,
    output logic        ft601_txe_n,
    input  logic        ft601_wr_n,
    input  logic        ft601_rd_n,
    input  logic        ft601_oe_n,
    input  logic        ft601_siwu_n,

    input  logic [35:0] host_tx_data,
    input  logic        host_tx_valid,
    output logic        host_tx_ready,

    output logic [35:0] host_rx_data,
    output logic        host_rx_valid,
    input  logic        host_rx_ready,

    output logic        proto_err,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Read FIFO: host -> master
    logic [35:0]   rd_mem [DEPTH];
    logic [AW-1:0] rd_wptr;
    logic [AW-1:0] rd_rptr;
    logic [CW-1:0] rd_count;
    logic [CW-1:0] rd_count_next;

    // Write FIFO: master -> host
    logic [35:0]   wr_mem [DEPTH];
    logic [AW-1:0] wr_wptr;
    logic [AW-1:0] wr_rptr;
    logic [CW-1:0] wr_count;
    logic [CW-1:0] wr_count_next;

    logic host_push;
    logic host_pop;
    logic master_pop;
    logic master_push;
    logic bus_conflict;
    logic unused_siwu;

    // Send-immediate has no meaning for this responder.
    assign unused_siwu = ft601_siwu_n;

    // The master must never drive data while asking us to drive it.
    assign bus_conflict = !ft601_wr_n && !ft601_oe_n;

    assign host_tx_ready = (rd_count != FULL);
    assign host_push     = host_tx_valid && host_tx_ready;

    // A read needs the pads turned around (oe_n low), no write strobe,
    // and data actually advertised through rxf_n.
    assign master_pop  = !ft601_oe_n && !ft601_rd_n && ft601_wr_n && !ft601_rxf_n;

    // A write needs the pads released (oe_n high) and space advertised.
    assign master_push = !ft601_wr_n && ft601_oe_n && !ft601_txe_n;

    assign host_rx_valid = (wr_count != '0);
    assign host_pop      = host_rx_valid && host_rx_ready;
    assign host_rx_data  = wr_mem[wr_rptr];

    assign {ft601_be_out, ft601_data_out} = (rd_count != '0) ? rd_mem[rd_rptr] : 36'd0;

    // Next occupancy of each FIFO; a simultaneous push and pop cancels out.
    always_comb begin
        rd_count_next = rd_count;
        wr_count_next = wr_count;
        if (host_push && !master_pop) begin
            rd_count_next = rd_count + CW'(1);
        end else if (!host_push && master_pop) begin
            rd_count_next = rd_count - CW'(1);
        end
        if (master_push && !host_pop) begin
            wr_count_next = wr_count + CW'(1);
        end else if (!master_push && host_pop) begin
            wr_count_next = wr_count - CW'(1);
        end
    end

    // Storage writes; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk) begin
        if (host_push) begin
            rd_mem[rd_wptr] <= host_tx_data;
        end
        if (master_push) begin
            wr_mem[wr_wptr] <= {ft601_be_in, ft601_data_in};
        end
    end

    // Pointers, counts, registered bus flags and statistics.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_wptr       <= '0;
            rd_rptr       <= '0;
            rd_count      <= '0;
            wr_wptr       <= '0;
            wr_rptr       <= '0;
            wr_count      <= '0;
            ft601_rxf_n   <= 1'b1;
            ft601_txe_n   <= 1'b1;
            ft601_data_oe <= 1'b0;
            proto_err     <= 1'b0;
            rd_cnt        <= 16'd0;
            wr_cnt        <= 16'd0;
        end else begin
            if (host_push) begin
                rd_wptr <= rd_wptr + AW'(1);
            end
            if (master_pop) begin
                rd_rptr <= rd_rptr + AW'(1);
                rd_cnt  <= rd_cnt + 16'd1;
            end
            if (master_push) begin
                wr_wptr <= wr_wptr + AW'(1);
                wr_cnt  <= wr_cnt + 16'd1;
            end
            if (host_pop) begin
                wr_rptr <= wr_rptr + AW'(1);
            end
            rd_count      <= rd_count_next;
            wr_count      <= wr_count_next;
            ft601_rxf_n   <= (rd_count_next == '0);
            ft601_txe_n   <= (wr_count_next == FULL);
            ft601_data_oe <= !ft601_oe_n && ft601_wr_n;
            if (bus_conflict) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pcileech_ft601_responder.sv
// Testbench for pcileech_ft601_responder.
// Expected words go into queues as stimulus is issued; two monitors pop
// and compare whenever the DUT hands a word to the master or the host.
module tb_pcileech_ft601_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ft601_data_in;
    logic [31:0] ft601_data_out;
    logic        ft601_data_oe;
    logic [3:0]  ft601_be_in;
    logic [3:0]  ft601_be_out;
    logic        ft601_rxf_n;
    logic        ft601_txe_n;
    logic        ft601_wr_n;
    logic        ft601_rd_n;
    logic        ft601_oe_n;
    logic        ft601_siwu_n;
    logic [35:0] host_tx_data;
    logic        host_tx_valid;
    logic        host_tx_ready;
    logic [35:0] host_rx_data;
    logic        host_rx_valid;
    logic        host_rx_ready;
    logic        proto_err;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    int errors = 0;
    int checks = 0;

    logic [35:0] rq[$];
    logic [35:0] wq[$];

    pcileech_ft601_responder #(.DEPTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ft601_data_in  (ft601_data_in),
        .ft601_data_out (ft601_data_out),
        .ft601_data_oe  (ft601_data_oe),
        .ft601_be_in    (ft601_be_in),
        .ft601_be_out   (ft601_be_out),
        .ft601_rxf_n    (ft601_rxf_n),
        .ft601_txe_n    (ft601_txe_n),
        .ft601_wr_n     (ft601_wr_n),
        .ft601_rd_n     (ft601_rd_n),
        .ft601_oe_n     (ft601_oe_n),
        .ft601_siwu_n   (ft601_siwu_n),
        .host_tx_data   (host_tx_data),
        .host_tx_valid  (host_tx_valid),
        .host_tx_ready  (host_tx_ready),
        .host_rx_data   (host_rx_data),
        .host_rx_valid  (host_rx_valid),
        .host_rx_ready  (host_rx_ready),
        .proto_err      (proto_err),
        .rd_cnt         (rd_cnt),
        .wr_cnt         (wr_cnt)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic oe, input logic rd, input logic wr);
        ft601_oe_n = oe;
        ft601_rd_n = rd;
        ft601_wr_n = wr;
    endtask

    task automatic hostPush(input logic [35:0] w);
        host_tx_valid = 1'b1;
        host_tx_data  = w;
        rq.push_back(w);
    endtask

    task automatic masterWrite(input logic [3:0] be, input logic [31:0] d, input bit expect_accept);
        ft601_wr_n    = 1'b0;
        ft601_be_in   = be;
        ft601_data_in = d;
        if (expect_accept) wq.push_back({be, d});
    endtask

    // Read-side monitor: a word leaves when the master completes a pop.
    always @(negedge clk) begin
        if (rst_n && !ft601_oe_n && !ft601_rd_n && ft601_wr_n && !ft601_rxf_n && ft601_data_oe) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rd_unexpected: got %h expected no word", {ft601_be_out, ft601_data_out});
            end else begin
                checkOutput("rd_word", {ft601_be_out, ft601_data_out}, rq.pop_front());
            end
        end
    end

    // Host-side monitor: a word leaves on every valid/ready handshake.
    always @(negedge clk) begin
        if (rst_n && host_rx_valid && host_rx_ready) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rx_unexpected: got %h expected no word", host_rx_data);
            end else begin
                checkOutput("rx_word", host_rx_data, wq.pop_front());
            end
        end
    end

    // Guard against a hung run.
    initial begin
        #(10 * 90000);
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        ft601_data_in = 32'd0;
        ft601_be_in   = 4'd0;
        ft601_siwu_n  = 1'b1;
        host_tx_data  = 36'd0;
        host_tx_valid = 1'b0;
        host_rx_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1);
        repeat (3) tick();

        // Reset state
        checkOutput("rst_rxf_n", ft601_rxf_n, 1);
        checkOutput("rst_txe_n", ft601_txe_n, 1);
        checkOutput("rst_data_oe", ft601_data_oe, 0);
        checkOutput("rst_data_out", {ft601_be_out, ft601_data_out}, 0);
        checkOutput("rst_proto_err", proto_err, 0);
        checkOutput("rst_rd_cnt", rd_cnt, 0);
        checkOutput("rst_wr_cnt", wr_cnt, 0);
        checkOutput("rst_rx_valid", host_rx_valid, 0);
        checkOutput("rst_tx_ready", host_tx_ready, 1);

        rst_n = 1'b1;
        tick();
        checkOutput("rel_txe_n", ft601_txe_n, 0);
        checkOutput("rel_rxf_n", ft601_rxf_n, 1);

        // Three-word read burst
        $display("[TB] read burst of 3");
        for (int i = 1; i <= 3; i++) begin
            hostPush({4'hF, 32'hA000_0000 + 32'(i)});
            tick();
        end
        host_tx_valid = 1'b0;
        checkOutput("rb_rxf_n", ft601_rxf_n, 0);
        checkOutput("rb_head", {ft601_be_out, ft601_data_out}, 36'hF_A000_0001);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("rb_data_oe", ft601_data_oe, 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("rb_rxf_n_empty", ft601_rxf_n, 1);
        checkOutput("rb_rd_cnt", rd_cnt, 3);
        checkOutput("rb_empty_out", {ft601_be_out, ft601_data_out}, 0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("rb_data_oe_off", ft601_data_oe, 0);

        // Sixteen writes fill the write FIFO; a 17th is ignored
        $display("[TB] write fill of 16");
        for (int i = 0; i < 16; i++) begin
            masterWrite(4'(i), 32'hC000_0000 + 32'(i), 1'b1);
            tick();
            if (i == 14) checkOutput("wf_txe_n_15", ft601_txe_n, 0);
        end
        checkOutput("wf_txe_n_full", ft601_txe_n, 1);
        masterWrite(4'hA, 32'hDEAD_BEEF, 1'b0);
        tick();
        ft601_wr_n = 1'b1;
        checkOutput("wf_wr_cnt", wr_cnt, 16);
        checkOutput("wf_txe_n_17", ft601_txe_n, 1);
        checkOutput("wf_proto_err", proto_err, 0);
        host_rx_ready = 1'b1;
        repeat (16) tick();
        host_rx_ready = 1'b0;
        checkOutput("wf_drained", host_rx_valid, 0);
        checkOutput("wf_txe_n_drained", ft601_txe_n, 0);

        // Simultaneous host push and master pop on the read FIFO
        $display("[TB] simultaneous read push/pop");
        hostPush({4'h3, 32'hB100_0001});
        tick();
        host_tx_valid = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick();
        hostPush({4'h5, 32'hB200_0002});
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        host_tx_valid = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("sim_rxf_n", ft601_rxf_n, 0);
        checkOutput("sim_head", {ft601_be_out, ft601_data_out}, 36'h5_B200_0002);
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("sim_rxf_n_empty", ft601_rxf_n, 1);
        checkOutput("sim_rd_cnt", rd_cnt, 5);

        // Simultaneous master push and host pop on the write FIFO
        masterWrite(4'h9, 32'h5100_0001, 1'b1);
        tick();
        masterWrite(4'h6, 32'h5200_0002, 1'b1);
        host_rx_ready = 1'b1;
        tick();
        ft601_wr_n = 1'b1;
        checkOutput("simw_valid", host_rx_valid, 1);
        tick();
        host_rx_ready = 1'b0;
        checkOutput("simw_empty", host_rx_valid, 0);
        checkOutput("simw_wr_cnt", wr_cnt, 18);

        // Bus conflict: wr_n and oe_n low together
        $display("[TB] bus conflict");
        hostPush({4'hF, 32'hC300_0003});
        tick();
        host_tx_valid = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("pe_flag", proto_err, 1);
        checkOutput("pe_data_oe", ft601_data_oe, 0);
        checkOutput("pe_rd_cnt", rd_cnt, 5);
        checkOutput("pe_wr_cnt", wr_cnt, 18);
        checkOutput("pe_rxf_n", ft601_rxf_n, 0);
        checkOutput("pe_no_push", host_rx_valid, 0);
        tick();
        checkOutput("pe_sticky", proto_err, 1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("pe_pop_after", rd_cnt, 6);

        // Read strobes while nothing is available are ignored
        repeat (2) tick();
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("ign_rd_cnt", rd_cnt, 6);
        checkOutput("ign_rxf_n", ft601_rxf_n, 1);

        // Reset in the middle of a 10-word burst
        $display("[TB] reset mid-burst");
        for (int i = 0; i < 10; i++) begin
            hostPush({4'hF, 32'hD000_0000 + 32'(i)});
            tick();
        end
        host_tx_valid = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (4) tick();
        rst_n = 1'b0;
        rq.delete();
        tick();
        checkOutput("mr_rd_cnt", rd_cnt, 0);
        checkOutput("mr_rxf_n", ft601_rxf_n, 1);
        checkOutput("mr_proto_err", proto_err, 0);
        checkOutput("mr_data_out", {ft601_be_out, ft601_data_out}, 0);
        checkOutput("mr_data_oe", ft601_data_oe, 0);
        checkOutput("mr_wr_cnt", wr_cnt, 0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("mr_txe_n", ft601_txe_n, 0);
        checkOutput("mr_rxf_n_rel", ft601_rxf_n, 1);

        // 65536 streaming pops wrap rd_cnt back to zero
        $display("[TB] 65536-word stream");
        applyStimulus(1'b0, 1'b1, 1'b1);
        tick();
        hostPush({4'h0, 32'hE000_0000});
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1);
        for (int i = 1; i < 65536; i++) begin
            hostPush({4'(i), 32'hE000_0000 | 32'(i)});
            tick();
        end
        host_tx_valid = 1'b0;
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("wrap_rd_cnt", rd_cnt, 0);
        checkOutput("wrap_rxf_n", ft601_rxf_n, 1);
        checkOutput("wrap_wr_cnt", wr_cnt, 0);
        checkOutput("wrap_proto_err", proto_err, 0);
        tick();

        checkOutput("rq_left", 36'(rq.size()), 0);
        checkOutput("wq_left", 36'(wq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
